lstm_seq_ctrl: RTL and testbench
================================

# lstm_seq_ctrl

Hardware sequencer for the LSTM layer and its output perceptron. It accepts input vectors over a valid/ready handshake and issues them to `network` one timestep at a time. After each timestep it enables `array_prod`, then returns one scalar result per timestep over a valid/ready handshake. It flushes the recurrent state between sequences of `SEQ_LEN` timesteps, replacing bench-driven sequencing.

## Interface
- `INPUT_SZ`, 2, elements per input vector
- `QN`, 6, integer bits; `QM`, 11, fractional bits; `BITWIDTH` = QN+QM+1 (derived)
- `SEQ_LEN`, 8, timesteps per sequence (≥1)
- `FLUSH_CYCLES`, 2, cycles `net_reset` is held between sequences (≥1)
- `TIMEOUT_CYCLES`, 1024, watchdog limit (used only with `LSTM_SEQ_WATCHDOG_EN`)
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in INPUT_SZ*BITWIDTH: input vector, element 0 in LSBs
- `net_input` out INPUT_SZ*BITWIDTH: registered vector to `network`
- `net_newSample` out 1: one-cycle start pulse to `network`
- `net_reset` out 1: active-high reset to `network`
- `net_dataReady` in 1: `network` done flag
- `perc_reset` out 1: active-high reset to `array_prod`
- `perc_dataReady` in 1 / `perc_result` in BITWIDTH: perceptron done flag and result
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out BITWIDTH / `out_last` out 1: result stream; `out_last` marks the final timestep of a sequence
- `busy` out 1: high in any state except IDLE
- `timeout` out 1: one-cycle watchdog pulse (constant 0 without the macro)

## Operation
- States: FLUSH → IDLE → ISSUE → WAIT_NET → GAP → PERC → OUT → (IDLE | FLUSH).
- FLUSH: `net_reset`=1 for `FLUSH_CYCLES` cycles; `step` clears to 0; then IDLE.
- IDLE: `in_ready`=1. When `in_valid & in_ready` at an edge, `in_data` is latched into `net_input` and the FSM moves to ISSUE.
- ISSUE: `net_newSample`=1 for exactly one cycle, then WAIT_NET.
- WAIT_NET: waits for a rising edge of `net_dataReady` (registered previous value 0, current 1). A level that is already high on entry does not complete the state. On the edge, go to GAP.
- GAP: one idle cycle, then PERC.
- PERC: `perc_reset`=0. The FSM leaves when `perc_dataReady`=1 is sampled, latching `perc_result` into `out_data`. `perc_reset` returns to 1 on the next cycle.
- OUT: `out_valid`=1, with `out_data` and `out_last` stable, until `out_valid & out_ready` at an edge. On that edge, if `step`==SEQ_LEN-1 then `step`←0 and the FSM goes to FLUSH; otherwise `step`+1 and IDLE.
- `out_last` = (`step`==SEQ_LEN-1) while in OUT.
- No arithmetic on data; values pass through unchanged as signed QN.QM.
- `in_valid` outside IDLE is ignored; the upstream source holds its data.

## Timing
- While `reset`=0, and in the cycle after it is released: state FLUSH, `net_reset`=1, `perc_reset`=1, `in_ready`=0, `net_newSample`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `net_input`=0, `busy`=1, `timeout`=0, `step`=0, flush counter restarted.
- First `in_ready`=1 comes `FLUSH_CYCLES` cycles after reset is released.
- Input accepted at edge t → `net_newSample` high during cycle t+1.
- Rising edge of `net_dataReady` seen at edge n → GAP in cycle n+1 → `perc_reset`=0 from cycle n+2.
- `perc_dataReady` seen at edge p → `out_valid`=1 from cycle p+1.
- If `out_ready` is already high, the handshake completes on the first `out_valid` cycle; `in_ready` rises on the following cycle, or FLUSH begins.
- Reset asserted mid-operation aborts everything: any pending output is dropped and the FSM re-enters FLUSH.

## Configuration
- `LSTM_SEQ_WATCHDOG_EN` defined: a counter runs in WAIT_NET and PERC and clears on entry to either state. When it reaches `TIMEOUT_CYCLES`, `timeout` pulses for one cycle and the FSM goes to FLUSH; the current timestep is discarded and no output is produced.
- Macro not defined: no counter; WAIT_NET and PERC wait indefinitely; `timeout` is tied to 0.

## Structure
- Package `lstm_seq_pkg`: FSM state enum, a `BITWIDTH` helper function, and a width function for `step` (`$clog2(SEQ_LEN)`, minimum 1).
- One sub-module, `seq_watchdog`: a clearable counter with a terminal-count pulse, instantiated only under the macro.

## Test plan
- Reset held low for 3 cycles, then released → all outputs at reset values; `in_ready` rises exactly 2 cycles after release.
- One vector {0x00800, 0x3F800}, behavioural network asserts `dataReady` 20 cycles after `newSample`, perceptron returns 0x00C00 → single-cycle `net_newSample`; `out_data`=0x00C00 with `out_last`=0.
- Full sequence of 8 vectors with `out_ready` always 1 → 8 outputs, only the 8th with `out_last`=1, then 2 cycles of `net_reset`=1 before `in_ready` returns.
- `out_ready` held low for 10 cycles → `out_valid` and `out_data` stable throughout; no new input accepted.
- `net_dataReady` held high on entry to WAIT_NET, then dropped and raised again → only the second rise advances the FSM; reset asserted during PERC → FLUSH, no output.
- With the macro defined and `TIMEOUT_CYCLES`=16, `net_dataReady` never rises → `timeout` pulses once 16 cycles into WAIT_NET, followed by FLUSH.

Source files
------------

// File: rtl/lstm_seq_pkg.sv
// Shared definitions for the LSTM sequencer.
//   seq_state_e : sequencer FSM states (also driven on the debug state port)
//   bitwidth()  : word width of a signed QN.QM value (sign + QN + QM)
//   step_width(): width of the timestep counter, at least one bit
package lstm_seq_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_NET = 3'd3,
    ST_GAP      = 3'd4,
    ST_PERC     = 3'd5,
    ST_OUT      = 3'd6
  } seq_state_e;

  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int step_width(input int seq_len);
    int w;
    w = $clog2(seq_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl_seq_watchdog.sv
// seq_watchdog: clearable cycle counter with a terminal-count pulse.
// Only instantiated when LSTM_SEQ_WATCHDOG_EN is defined.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   clear_i : forces the count to zero (held while the guarded wait is not active)
//   en_i    : count one per cycle while high
//   fire_o  : high for the cycle in which LIMIT enabled cycles have elapsed
module seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic fire_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // The count runs 0..LIMIT-1, so the pulse lands in the LIMIT-th enabled cycle.
  assign fire_o = en_i && !clear_i && (cnt_q == TC);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i || fire_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequences input vectors through the LSTM `network` and the
// `array_prod` perceptron, one timestep at a time, and returns one scalar per
// timestep. The recurrent state is flushed (net_reset) between sequences of
// SEQ_LEN timesteps. Optional watchdog: define LSTM_SEQ_WATCHDOG_EN.
//
// Ports
//   clock, reset                  : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready/in_data     : input vector stream, element 0 in the LSBs
//   net_input, net_newSample      : latched vector and one-cycle start pulse to network
//   net_reset, net_dataReady      : active-high network reset, network done flag
//   perc_reset                    : active-high perceptron reset (low only in PERC)
//   perc_dataReady, perc_result   : perceptron done flag and result
//   out_valid/out_ready/out_data/out_last : result stream, out_last on final timestep
//   busy                          : high in every state except IDLE
//   timeout                       : one-cycle watchdog pulse (0 without the macro)
//   dbg_state_o                   : current FSM state
//
// Handshakes: a transfer happens at a rising clock edge where valid and ready
// are both high. Once out_valid is raised, out_data/out_last stay stable until
// that transfer; in_valid is only looked at while in_ready is high.
module lstm_seq_ctrl
  import lstm_seq_pkg::*;
#(
  parameter int INPUT_SZ       = 2,
  parameter int QN             = 6,
  parameter int QM             = 11,
  parameter int SEQ_LEN        = 8,
  parameter int FLUSH_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BITWIDTH      = bitwidth(QN, QM)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_SZ*BITWIDTH-1:0] in_data,
  output logic [INPUT_SZ*BITWIDTH-1:0] net_input,
  output logic                         net_newSample,
  output logic                         net_reset,
  input  logic                         net_dataReady,
  output logic                         perc_reset,
  input  logic                         perc_dataReady,
  input  logic [BITWIDTH-1:0]          perc_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITWIDTH-1:0]          out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         timeout,
  output seq_state_e                   dbg_state_o
);

  localparam int STEP_W  = step_width(SEQ_LEN);
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(SEQ_LEN - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  if (SEQ_LEN < 1 || FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("lstm_seq_ctrl: SEQ_LEN, FLUSH_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_e                  state_q, state_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic [FLUSH_W-1:0]          flush_cnt_q, flush_cnt_d;
  logic [INPUT_SZ*BITWIDTH-1:0] net_input_q, net_input_d;
  logic [BITWIDTH-1:0]         out_data_q, out_data_d;
  logic                        ndr_prev_q;
  logic                        ndr_rise;
  logic                        wd_fire;

  // Only a 0->1 transition counts as "network done": a flag left high from the
  // previous timestep must not complete the new one.
  assign ndr_rise = net_dataReady & ~ndr_prev_q;

`ifdef LSTM_SEQ_WATCHDOG_EN
  logic wd_run;
  assign wd_run = (state_q == ST_WAIT_NET) || (state_q == ST_PERC);

  seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_seq_watchdog (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (!wd_run),
    .en_i    (wd_run),
    .fire_o  (wd_fire)
  );
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    flush_cnt_d   = '0;
    net_input_d   = net_input_q;
    out_data_d    = out_data_q;
    in_ready      = 1'b0;
    net_newSample = 1'b0;
    net_reset     = 1'b0;
    perc_reset    = 1'b1;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = 1'b1;
    timeout       = 1'b0;

    unique case (state_q)
      ST_FLUSH: begin
        net_reset   = 1'b1;
        step_d      = '0;
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          net_input_d = in_data;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        net_newSample = 1'b1;
        state_d       = ST_WAIT_NET;
      end
      ST_WAIT_NET: begin
        // A watchdog expiry wins so that a timeout pulse always means a flush.
        if (wd_fire) begin
          timeout = 1'b1;
          state_d = ST_FLUSH;
        end else if (ndr_rise) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_PERC;
      end
      ST_PERC: begin
        perc_reset = 1'b0;
        if (wd_fire) begin
          timeout = 1'b1;
          state_d = ST_FLUSH;
        end else if (perc_dataReady) begin
          out_data_d = perc_result;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = (step_q == LAST_STEP);
        if (out_ready) begin
          if (step_q == LAST_STEP) begin
            step_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_FLUSH;
      step_q      <= '0;
      flush_cnt_q <= '0;
      net_input_q <= '0;
      out_data_q  <= '0;
      ndr_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      flush_cnt_q <= flush_cnt_d;
      net_input_q <= net_input_d;
      out_data_q  <= out_data_d;
      ndr_prev_q  <= net_dataReady;
    end
  end

  assign net_input   = net_input_q;
  assign out_data    = out_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: behavioural network/perceptron responders driven
// inline per timestep, an expected-output queue filled from the perceptron
// results and the bench's own timestep position, and a final report.
module tb_lstm_seq_ctrl;
  import lstm_seq_pkg::*;

  localparam int INPUT_SZ     = 2;
  localparam int QN           = 6;
  localparam int QM           = 11;
  localparam int BW           = QN + QM + 1;
  localparam int VW           = INPUT_SZ * BW;
  localparam int SEQ_LEN      = 8;
  localparam int FLUSH_CYCLES = 2;
`ifdef LSTM_SEQ_WATCHDOG_EN
  localparam int TIMEOUT_CYCLES = 16;
`else
  localparam int TIMEOUT_CYCLES = 1024;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [VW-1:0] net_input;
  logic          net_newSample;
  logic          net_reset;
  logic          net_dataReady;
  logic          perc_reset;
  logic          perc_dataReady;
  logic [BW-1:0] perc_result;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          timeout;
  seq_state_e    dbg_state;

  lstm_seq_ctrl #(
    .INPUT_SZ       (INPUT_SZ),
    .QN             (QN),
    .QM             (QM),
    .SEQ_LEN        (SEQ_LEN),
    .FLUSH_CYCLES   (FLUSH_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .net_input      (net_input),
    .net_newSample  (net_newSample),
    .net_reset      (net_reset),
    .net_dataReady  (net_dataReady),
    .perc_reset     (perc_reset),
    .perc_dataReady (perc_dataReady),
    .perc_result    (perc_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .timeout        (timeout),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_time_limit act=running exp=finished");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [BW:0] exp_q[$];   // {last, data}
  int seq_pos = 0;         // timestep position within the current sequence

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_net_reset"}, net_reset, 1);
    chk({tag, "_perc_reset"}, perc_reset, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_new_sample"}, net_newSample, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_net_input"}, net_input, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_state"}, dbg_state, ST_FLUSH);
  endtask

  // ---------------- driver tasks ----------------
  // Holds reset low for n cycles (inputs are cleared after the first edge so a
  // response pending at assertion time meets the reset), then releases it and
  // checks the flush timing.
  task automatic do_reset(input int n);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready      = 1'b0;
    net_dataReady  = 1'b0;
    perc_dataReady = 1'b0;
    exp_q.delete();
    seq_pos = 0;
    repeat (n - 1) tick();
    check_reset_vals("rst_low");
    reset = 1'b1;
    tick();
    check_reset_vals("rst_after");
    tick();
    chk("rst_in_ready_rise", in_ready, 1);
    chk("rst_idle_net_reset", net_reset, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VW-1:0];
  endfunction

  function automatic logic [BW-1:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    return r[BW-1:0];
  endfunction

  // mode 0: normal timestep
  // mode 1: net_dataReady already high on entry to WAIT_NET, then dropped and raised
  // mode 2: reset asserted in PERC while the perceptron answers
  // mode 3: network never answers (watchdog build only)
  task automatic run_step(input logic [VW-1:0] vec, input int net_lat, input int perc_lat,
                          input logic [BW-1:0] pres, input int ready_delay, input int mode);
    int w;
    logic last_exp;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_wait_expired", 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_data   = vec;
    out_ready = (ready_delay == 0);
    tick();
    in_valid = 1'b0;
    in_data  = rand_vec();
    chk("new_sample_on", net_newSample, 1);
    chk("net_input_latched", net_input, vec);
    chk("in_ready_after_accept", in_ready, 0);
    if (mode != 1) net_dataReady = 1'b0;
    tick();
    chk("new_sample_single", net_newSample, 0);

    if (mode == 3) begin
      for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
        chk("timeout_early", timeout, 0);
        tick();
      end
      chk("timeout_pulse", timeout, 1);
      tick();
      chk("timeout_single", timeout, 0);
      chk("timeout_flush", net_reset, 1);
      chk("timeout_no_out", out_valid, 0);
      seq_pos = 0;
      return;
    end

    if (mode == 1) begin
      repeat (5) tick();
      chk("ndr_level_ignored", perc_reset, 1);
      net_dataReady = 1'b0;
      repeat (2) tick();
      chk("ndr_low_still_waiting", perc_reset, 1);
    end

    repeat (net_lat) tick();
    chk("net_wait_perc_reset", perc_reset, 1);
    net_dataReady = 1'b1;
    tick();
    chk("gap_perc_reset", perc_reset, 1);
    tick();
    chk("perc_reset_low", perc_reset, 0);

    if (mode == 2) begin
      perc_dataReady = 1'b1;
      perc_result    = pres;
      do_reset(2);
      chk("abort_no_out", out_valid, 0);
      return;
    end

    repeat (perc_lat) tick();
    chk("perc_wait_no_out", out_valid, 0);
    chk("perc_wait_perc_reset", perc_reset, 0);
    last_exp = (seq_pos == SEQ_LEN - 1);
    exp_q.push_back({last_exp, pres});
    perc_dataReady = 1'b1;
    perc_result    = pres;
    tick();
    perc_dataReady = 1'b0;
    perc_result    = rand_word();
    chk("perc_reset_back", perc_reset, 1);
    chk("out_valid_on", out_valid, 1);

    if (ready_delay > 0) begin
      in_valid = 1'b1;
      in_data  = rand_vec();
    end
    for (int i = 0; i < ready_delay; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data", out_data, exp_q[0][BW-1:0]);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("hs_out_valid", out_valid, 1);
    chk("hs_out_data", out_data, exp_q[0][BW-1:0]);
    chk("hs_out_last", out_last, exp_q[0][BW]);
    chk("hs_net_input_kept", net_input, vec);
    chk("hs_timeout", timeout, 0);
    void'(exp_q.pop_front());
    seq_pos = (seq_pos + 1) % SEQ_LEN;
    tick();
    chk("post_out_valid", out_valid, 0);
    if (last_exp) begin
      chk("flush0_net_reset", net_reset, 1);
      chk("flush0_in_ready", in_ready, 0);
      tick();
      chk("flush1_net_reset", net_reset, 1);
      tick();
      chk("flush_done_in_ready", in_ready, 1);
      chk("flush_done_net_reset", net_reset, 0);
    end else begin
      chk("next_in_ready", in_ready, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    net_dataReady  = 1'b0;
    perc_dataReady = 1'b0;
    perc_result    = '0;
    out_ready      = 1'b0;

    do_reset(3);

    // First sequence: directed first vector, then random, out_ready always high.
    run_step({18'h3F800, 18'h00800}, 20, 2, 18'h00C00, 0, 0);
    for (int i = 1; i < SEQ_LEN; i++) begin
      run_step(rand_vec(), $urandom_range(0, 6), $urandom_range(0, 4), rand_word(), 0, 0);
    end

    // Second sequence: back-pressure on one step, held network flag on another.
    for (int i = 0; i < SEQ_LEN; i++) begin
      run_step(rand_vec(), $urandom_range(0, 6), $urandom_range(0, 4), rand_word(),
               (i == 2) ? 10 : $urandom_range(0, 2), (i == 4) ? 1 : 0);
    end

    // Partial sequence, then reset during PERC.
    for (int i = 0; i < 3; i++) begin
      run_step(rand_vec(), $urandom_range(0, 4), $urandom_range(0, 3), rand_word(), 0, 0);
    end
    run_step(rand_vec(), 3, 0, rand_word(), 0, 2);

`ifdef LSTM_SEQ_WATCHDOG_EN
    run_step(rand_vec(), 0, 0, rand_word(), 0, 3);
`endif

    // Recovery: a few more timesteps starting from position 0.
    for (int i = 0; i < 3; i++) begin
      run_step(rand_vec(), $urandom_range(0, 5), $urandom_range(0, 3), rand_word(),
               $urandom_range(0, 3), 0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
